// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Bridges a CPU load/store request port onto a byte-wide data RAM. Every RAM
// access is a single byte. A word request is split into four byte accesses
// at addr+0..addr+3 in little-endian order. A byte request makes a single
// access. An address fault is answered without touching the RAM.
//
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   req_valid/ready   request handshake; ready only while idle
//   req_we            1 = store, 0 = load
//   req_size          0 = word, 1 = byte
//   req_unsigned      byte load: 1 = zero-extend, 0 = sign-extend
//   req_addr          32-bit CPU byte address (legal window 0x1000..0x1FFF)
//   req_wdata         store data
//   resp_valid        one-cycle completion pulse
//   resp_rdata        load result (0 for stores, errors and idle cycles)
//   resp_err          address fault, qualified by resp_valid
//   ram_we            RAM byte write enable
//   ram_dataType      RAM access type, constant 1 (byte)
//   ram_A             RAM byte address
//   ram_WD            RAM write data, byte in [7:0], upper bits zero
//   ram_RD            RAM asynchronous read data, byte in [7:0]
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int ADDRESS_WIDTH = 12,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic                     req_size,
  input  logic                     req_unsigned,
  input  logic [31:0]              req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_err,
  output logic                     ram_we,
  output logic                     ram_dataType,
  output logic [ADDRESS_WIDTH-1:0] ram_A,
  output logic [DATA_WIDTH-1:0]    ram_WD,
  input  logic [DATA_WIDTH-1:0]    ram_RD
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Registered request and FSM state.
  state_e                   state_q, state_d;
  logic [1:0]               k_q, k_d;
  logic                     we_q, we_d;
  logic                     size_q, size_d;
  logic                     uns_q, uns_d;
  logic [11:0]              addr_q, addr_d;
  logic [31:0]              wdata_q, wdata_d;
  logic [3:0][7:0]          lanes_q, lanes_d;

  // Registered outputs.
  logic                     ram_we_q, ram_we_d;
  logic [ADDRESS_WIDTH-1:0] ram_a_q, ram_a_d;
  logic [DATA_WIDTH-1:0]    ram_wd_q, ram_wd_d;
  logic                     resp_valid_q, resp_valid_d;
  logic                     resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0]    resp_rdata_q, resp_rdata_d;

  logic                     req_fault;
  logic                     last_byte;
  logic [31:0]              load_result;

  // Only the low byte of the RAM read bus carries data.
  logic                     unused_rd_bits;
  assign unused_rd_bits = ^ram_RD[DATA_WIDTH-1:8];

  // Legal window is 0x1000..0x1FFF; a word must also fit entirely inside it.
  assign req_fault = (req_addr[31:12] != 20'h00001) ||
                     (!req_size && (req_addr[11:0] > 12'hFFC));

  assign last_byte = size_q || (k_q == 2'd3);

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the case leaves one unassigned and infers a latch.
    state_d      = state_q;
    k_d          = k_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    lanes_d      = lanes_q;
    ram_we_d     = 1'b0;
    ram_a_d      = '0;
    ram_wd_d     = '0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    load_result  = '0;

    case (state_q)
      ST_IDLE: begin
        // req_ready is 1 throughout IDLE, so req_valid alone means acceptance.
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr[11:0];
          wdata_d = req_wdata[31:0];
          k_d     = 2'd0;
          if (req_fault) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            // Outputs are registered, so the first byte's RAM controls are
            // set up here and appear in the first ACCESS cycle.
            state_d  = ST_ACCESS;
            ram_we_d = req_we;
            ram_a_d  = ADDRESS_WIDTH'(req_addr[11:0]);
            ram_wd_d = DATA_WIDTH'(req_wdata[7:0]);
          end
        end
      end

      ST_ACCESS: begin
        if (!we_q) lanes_d[k_q] = ram_RD[7:0];
        if (last_byte) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          if (size_q) begin
            load_result = uns_q ? {24'h0, lanes_d[0]}
                                : {{24{lanes_d[0][7]}}, lanes_d[0]};
          end else begin
            load_result = lanes_d;
          end
          if (!we_q) resp_rdata_d = DATA_WIDTH'(load_result);
        end else begin
          k_d      = k_q + 2'd1;
          ram_we_d = we_q;
          ram_a_d  = ADDRESS_WIDTH'(addr_q + 12'(k_d));
          ram_wd_d = DATA_WIDTH'(wdata_q[{k_d, 3'b000} +: 8]);
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        k_d     = 2'd0;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of its inputs regardless of order.
    if (rst) begin
      // NOTE: the result lanes are a handful of flops, not a memory array,
      // so they are cleared with the rest of the state.
      state_q      <= ST_IDLE;
      k_q          <= 2'd0;
      we_q         <= 1'b0;
      size_q       <= 1'b0;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      lanes_q      <= '0;
      ram_we_q     <= 1'b0;
      ram_a_q      <= '0;
      ram_wd_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      lanes_q      <= lanes_d;
      ram_we_q     <= ram_we_d;
      ram_a_q      <= ram_a_d;
      ram_wd_q     <= ram_wd_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  // The RAM samples ram_we on the same edge that applies reset; gating with
  // rst keeps the byte in flight from being written when reset aborts a store.
  assign ram_we       = ram_we_q && !rst;
  assign ram_dataType = 1'b1;
  assign ram_A        = ram_a_q;
  assign ram_WD       = ram_wd_q;
  assign resp_valid   = resp_valid_q;
  assign resp_err     = resp_err_q;
  assign resp_rdata   = resp_rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Directed testbench for mem_access_ctrl with a behavioural byte RAM
// (asynchronous read, write on the rising edge). Expected values are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        ram_we;
  logic        ram_dataType;
  logic [11:0] ram_A;
  logic [31:0] ram_WD;
  logic [31:0] ram_RD;

  int errors = 0;
  int checks = 0;

  // Byte RAM model.
  logic [7:0] mem [0:4095];
  assign ram_RD = {24'h0, mem[ram_A]};
  always @(posedge clk) if (ram_we) mem[ram_A] <= ram_WD[7:0];

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDRESS_WIDTH(12), .DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .ram_we       (ram_we),
    .ram_dataType (ram_dataType),
    .ram_A        (ram_A),
    .ram_WD       (ram_WD),
    .ram_RD       (ram_RD)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Per-request observations.
  logic [11:0] wr_a [0:7];
  logic [7:0]  wr_d [0:7];
  logic        rdy  [1:8];
  int          quiet_bad = 0;   // resp_rdata/resp_err nonzero while resp_valid = 0
  int          busy_ready = 0;  // req_ready seen high while busy

  // Issues one request at cycle N and watches cycles N+1..N+8.
  // lat = cycle offset of resp_valid (-1 if it never came).
  task automatic run_req(input logic we, input logic size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rdata,
                         output logic err, output int nwr);
    lat = -1; rdata = '0; err = 1'b0; nwr = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    check("ready_before", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    // Scramble request inputs while busy; the registered copy must be used.
    req_valid = 1'b0; req_we = ~we; req_size = ~size; req_unsigned = ~uns;
    req_addr = 32'h0000_1FF0; req_wdata = 32'hFFFF_FFFF;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      rdy[i] = req_ready;
      if (lat < 0 && req_ready) busy_ready++;
      if (ram_we && nwr < 8) begin
        wr_a[nwr] = ram_A;
        wr_d[nwr] = ram_WD[7:0];
        nwr++;
      end
      if (!resp_valid && (resp_rdata != 32'h0 || resp_err)) quiet_bad++;
      if (resp_valid && lat < 0) begin
        lat = i; rdata = resp_rdata; err = resp_err;
      end
    end
    if (lat >= 1 && lat <= 7) check("ready_after_resp", {31'b0, rdy[lat+1]}, 32'd1);
    else check("resp_seen", 32'(lat), 32'd1);
  endtask

  int          lat, nwr, nresp, nwe;
  logic [31:0] rdata;
  logic        err;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 1'b0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_ready",      {31'b0, req_ready},    32'd1);
    check("rst_resp_valid", {31'b0, resp_valid},   32'd0);
    check("rst_resp_err",   {31'b0, resp_err},     32'd0);
    check("rst_resp_rdata", resp_rdata,            32'd0);
    check("rst_ram_we",     {31'b0, ram_we},       32'd0);
    check("rst_ram_A",      {20'b0, ram_A},        32'd0);
    check("rst_ram_WD",     ram_WD,                32'd0);
    check("data_type",      {31'b0, ram_dataType}, 32'd1);

    // Word store 0x1010 <- 0xA1B2C3D4.
    run_req(1'b1, 1'b0, 1'b0, 32'h0000_1010, 32'hA1B2_C3D4, lat, rdata, err, nwr);
    check("wst_lat",   32'(lat), 32'd5);
    check("wst_err",   {31'b0, err}, 32'd0);
    check("wst_rdata", rdata, 32'd0);
    check("wst_nwr",   32'(nwr), 32'd4);
    check("wst_a0", {20'b0, wr_a[0]}, 32'h010); check("wst_d0", {24'b0, wr_d[0]}, 32'hD4);
    check("wst_a1", {20'b0, wr_a[1]}, 32'h011); check("wst_d1", {24'b0, wr_d[1]}, 32'hC3);
    check("wst_a2", {20'b0, wr_a[2]}, 32'h012); check("wst_d2", {24'b0, wr_d[2]}, 32'hB2);
    check("wst_a3", {20'b0, wr_a[3]}, 32'h013); check("wst_d3", {24'b0, wr_d[3]}, 32'hA1);

    // Word load back.
    run_req(1'b0, 1'b0, 1'b0, 32'h0000_1010, 32'h0, lat, rdata, err, nwr);
    check("wld_lat",   32'(lat), 32'd5);
    check("wld_rdata", rdata, 32'hA1B2_C3D4);
    check("wld_nwr",   32'(nwr), 32'd0);

    // Byte loads of 0xA1, signed then unsigned.
    run_req(1'b0, 1'b1, 1'b0, 32'h0000_1013, 32'h0, lat, rdata, err, nwr);
    check("bld_s_lat",   32'(lat), 32'd2);
    check("bld_s_rdata", rdata, 32'hFFFF_FFA1);
    run_req(1'b0, 1'b1, 1'b1, 32'h0000_1013, 32'h0, lat, rdata, err, nwr);
    check("bld_u_lat",   32'(lat), 32'd2);
    check("bld_u_rdata", rdata, 32'h0000_00A1);

    // Byte store of a positive byte, then signed load stays positive.
    run_req(1'b1, 1'b1, 1'b0, 32'h0000_1020, 32'h1234_565A, lat, rdata, err, nwr);
    check("bst_lat", 32'(lat), 32'd2);
    check("bst_nwr", 32'(nwr), 32'd1);
    check("bst_a0",  {20'b0, wr_a[0]}, 32'h020);
    check("bst_d0",  {24'b0, wr_d[0]}, 32'h5A);
    run_req(1'b0, 1'b1, 1'b0, 32'h0000_1020, 32'h0, lat, rdata, err, nwr);
    check("bld_pos_rdata", rdata, 32'h0000_005A);

    // Misaligned word load 0x1011 spans 0x011..0x014.
    run_req(1'b1, 1'b1, 1'b0, 32'h0000_1014, 32'h0000_0077, lat, rdata, err, nwr);
    run_req(1'b0, 1'b0, 1'b0, 32'h0000_1011, 32'h0, lat, rdata, err, nwr);
    check("mis_lat",   32'(lat), 32'd5);
    check("mis_rdata", rdata, 32'h77A1_B2C3);

    // Word store straddling the top of the window faults.
    run_req(1'b1, 1'b0, 1'b0, 32'h0000_1FFD, 32'h5566_7788, lat, rdata, err, nwr);
    check("wst_fault_lat", 32'(lat), 32'd1);
    check("wst_fault_err", {31'b0, err}, 32'd1);
    check("wst_fault_nwr", 32'(nwr), 32'd0);

    // Highest legal word store.
    run_req(1'b1, 1'b0, 1'b0, 32'h0000_1FFC, 32'h1122_3344, lat, rdata, err, nwr);
    check("top_lat", 32'(lat), 32'd5);
    check("top_err", {31'b0, err}, 32'd0);
    check("top_nwr", 32'(nwr), 32'd4);
    check("top_a0", {20'b0, wr_a[0]}, 32'hFFC); check("top_d0", {24'b0, wr_d[0]}, 32'h44);
    check("top_a3", {20'b0, wr_a[3]}, 32'hFFF); check("top_d3", {24'b0, wr_d[3]}, 32'h11);
    run_req(1'b0, 1'b1, 1'b1, 32'h0000_1FFF, 32'h0, lat, rdata, err, nwr);
    check("top_bld_rdata", rdata, 32'h0000_0011);

    // Out-of-range loads.
    run_req(1'b0, 1'b0, 1'b0, 32'h0000_0800, 32'h0, lat, rdata, err, nwr);
    check("oor_lat",   32'(lat), 32'd1);
    check("oor_err",   {31'b0, err}, 32'd1);
    check("oor_rdata", rdata, 32'd0);
    run_req(1'b0, 1'b1, 1'b0, 32'h0000_2000, 32'h0, lat, rdata, err, nwr);
    check("oor_hi_err", {31'b0, err}, 32'd1);
    check("oor_hi_nwr", 32'(nwr), 32'd0);

    check("quiet_when_idle", 32'(quiet_bad), 32'd0);
    check("ready_low_busy",  32'(busy_ready), 32'd0);

    // Reset in the second ACCESS cycle of a word store.
    run_req(1'b1, 1'b0, 1'b0, 32'h0000_1030, 32'h0, lat, rdata, err, nwr);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 1'b0; req_unsigned = 1'b0;
    req_addr = 32'h0000_1030; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("abort_we0", {31'b0, ram_we}, 32'd1);
    check("abort_d0",  ram_WD, 32'h0000_00EF);
    @(negedge clk);
    check("abort_a1",  {20'b0, ram_A}, 32'h031);
    rst = 1'b1;
    #1;
    check("abort_we_gated", {31'b0, ram_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nresp = 0; nwe = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) check("abort_ready", {31'b0, req_ready}, 32'd1);
      if (resp_valid) nresp++;
      if (ram_we) nwe++;
    end
    check("abort_no_resp", 32'(nresp), 32'd0);
    check("abort_no_we",   32'(nwe), 32'd0);
    check("abort_m30", {24'b0, mem[12'h030]}, 32'hEF);
    check("abort_m31", {24'b0, mem[12'h031]}, 32'h00);
    check("abort_m33", {24'b0, mem[12'h033]}, 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
